// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
package gray_pkg;

  // Widest counter the helper functions cover; narrower values are zero-extended.
  localparam int unsigned GRAY_MAXW = 32;

  // End-of-range behaviour selectors for the SATURATE parameter.
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary: each bit is the XOR of all bits at or above it.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b = '0;
    for (int i = 0; i < int'(GRAY_MAXW); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ud.sv
// Up/down binary counter with same-cycle Gray encoding, load, and wrap/saturate ends.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int unsigned CBITS    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CBITS-1:0] load_val,
  output logic [CBITS-1:0] bin_c,
  output logic [CBITS-1:0] gray_c,
  output logic             sig,
  output logic             at_end,
  output logic             wrap
);

  localparam logic [CBITS-1:0] MAX_VAL  = '1;
  localparam logic [CBITS-1:0] ZERO_VAL = '0;
  localparam logic [CBITS-1:0] ONE_VAL  = CBITS'(1);
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [CBITS-1:0] r_bin;
  logic [CBITS-1:0] r_gray;
  logic             r_wrap;

  logic [CBITS-1:0] w_bin_nxt;
  logic [CBITS-1:0] w_gray_nxt;
  logic             w_wrap_nxt;

  // Next binary value and end-crossing flag; priority load > en > hold.
  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = load_val;
    end else if (en) begin
      if (up) begin
        if (r_bin == MAX_VAL) begin
          if (!SAT_MODE) begin
            w_bin_nxt  = ZERO_VAL;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin + ONE_VAL;
        end
      end else begin
        if (r_bin == ZERO_VAL) begin
          if (!SAT_MODE) begin
            w_bin_nxt  = MAX_VAL;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin - ONE_VAL;
        end
      end
    end
  end

  // Gray is encoded from the next binary value so both registers move together.
  always_comb begin
    w_gray_nxt = CBITS'(bin2gray(GRAY_MAXW'(w_bin_nxt)));
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bin_c  = r_bin;
  assign gray_c = r_gray;
  assign wrap   = r_wrap;
  assign sig    = (r_bin == ZERO_VAL) & ~rst;
  assign at_end = up ? (r_bin == MAX_VAL) : (r_bin == ZERO_VAL);

  // Gray output always encodes the binary output, in both directions of conversion.
  a_gray_enc : assert property (@(posedge clk) disable iff (rst)
    (gray_c == CBITS'(bin2gray(GRAY_MAXW'(bin_c)))) && (bin_c == CBITS'(gray2bin(GRAY_MAXW'(gray_c)))));

  // A counting edge moves gray_c by exactly one bit; only a saturated end may hold it.
  a_gray_step : assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && $past(en) && !$past(load)) |->
      ($onehot(gray_c ^ $past(gray_c)) || (SAT_MODE && (gray_c == $past(gray_c)))));

  // In wrap mode, uninterrupted counting must reach zero within one full revolution.
  if (!SAT_MODE) begin : g_live
    logic [CBITS:0] r_live_cnt;

    // Counts consecutive counting edges taken while the count is away from zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_live_cnt <= '0;
      end else if (sig || !en || load) begin
        r_live_cnt <= '0;
      end else if (r_live_cnt != {1'b1, ZERO_VAL}) begin
        r_live_cnt <= r_live_cnt + (CBITS + 1)'(1);
      end
    end

    a_live : assert property (@(posedge clk) disable iff (rst)
      r_live_cnt <= (CBITS + 1)'(MAX_VAL));
  end

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed bench: a wrap-mode and a saturate-mode counter driven by the same stimulus.
module tb_gray_counter_ud;

  localparam int unsigned CBITS = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [CBITS-1:0] load_val;

  logic [CBITS-1:0] w_bin_w, w_gray_w, w_bin_s, w_gray_s;
  logic             w_sig_w, w_end_w, w_wrap_w, w_sig_s, w_end_s, w_wrap_s;

  int total;
  int bad;

  gray_counter_ud #(.CBITS(CBITS), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_c(w_bin_w), .gray_c(w_gray_w), .sig(w_sig_w), .at_end(w_end_w), .wrap(w_wrap_w)
  );

  gray_counter_ud #(.CBITS(CBITS), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_c(w_bin_s), .gray_c(w_gray_s), .sig(w_sig_s), .at_end(w_end_s), .wrap(w_wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks bin, gray and wrap of the wrap-mode counter.
  task automatic chk_w(input string tag, input logic [7:0] b, input logic [7:0] g, input logic wr);
    chk({tag, ".w.bin"}, 32'(w_bin_w), 32'(b));
    chk({tag, ".w.gray"}, 32'(w_gray_w), 32'(g));
    chk({tag, ".w.wrap"}, 32'(w_wrap_w), 32'(wr));
  endtask

  // Checks bin, gray and wrap of the saturate-mode counter.
  task automatic chk_s(input string tag, input logic [7:0] b, input logic [7:0] g, input logic wr);
    chk({tag, ".s.bin"}, 32'(w_bin_s), 32'(b));
    chk({tag, ".s.gray"}, 32'(w_gray_s), 32'(g));
    chk({tag, ".s.wrap"}, 32'(w_wrap_s), 32'(wr));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset held for three cycles.
    repeat (3) step();
    chk_w("rst", 8'h00, 8'h00, 1'b0);
    chk_s("rst", 8'h00, 8'h00, 1'b0);
    chk("rst.sig", 32'(w_sig_w), 32'd0);

    // Release and count up: Gray 00,01,03,02,06.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk("rel.sig", 32'(w_sig_w), 32'd1);
    chk("rel.at_end", 32'(w_end_w), 32'd0);
    step(); chk_w("up1", 8'h01, 8'h01, 1'b0); chk("up1.sig", 32'(w_sig_w), 32'd0);
    step(); chk_w("up2", 8'h02, 8'h03, 1'b0);
    step(); chk_w("up3", 8'h03, 8'h02, 1'b0);
    step(); chk_w("up4", 8'h04, 8'h06, 1'b0); chk_s("up4", 8'h04, 8'h06, 1'b0);

    // Load 0xFE (load wins over en), then climb to MAX.
    load = 1'b1; load_val = 8'hFE;
    step(); chk_w("ldFE", 8'hFE, 8'h81, 1'b0); chk_s("ldFE", 8'hFE, 8'h81, 1'b0);
    load = 1'b0;
    step(); chk_w("toFF", 8'hFF, 8'h80, 1'b0); chk_s("toFF", 8'hFF, 8'h80, 1'b0);
    chk("toFF.w.end", 32'(w_end_w), 32'd1);
    chk("toFF.s.end", 32'(w_end_s), 32'd1);

    // Upper end: wrap mode rolls to 0 with a pulse, saturate mode holds MAX.
    step();
    chk_w("wrapup", 8'h00, 8'h00, 1'b1); chk("wrapup.sig", 32'(w_sig_w), 32'd1);
    chk_s("hold1", 8'hFF, 8'h80, 1'b0); chk("hold1.end", 32'(w_end_s), 32'd1);
    step(); chk_w("after", 8'h01, 8'h01, 1'b0); chk_s("hold2", 8'hFF, 8'h80, 1'b0);
    step(); chk_w("w2", 8'h02, 8'h03, 1'b0); chk_s("hold3", 8'hFF, 8'h80, 1'b0);
    step(); chk_w("w3", 8'h03, 8'h02, 1'b0); chk_s("hold4", 8'hFF, 8'h80, 1'b0);

    // Direction change leaves saturation immediately.
    up = 1'b0;
    step(); chk_s("dn", 8'hFE, 8'h81, 1'b0); chk_w("dn", 8'h02, 8'h03, 1'b0);

    // Load 0x80 with en & down asserted: load wins, then one down step.
    load = 1'b1; load_val = 8'h80;
    step(); chk_w("ld80", 8'h80, 8'hC0, 1'b0); chk_s("ld80", 8'h80, 8'hC0, 1'b0);
    load = 1'b0;
    step(); chk_w("to7F", 8'h7F, 8'h40, 1'b0); chk_s("to7F", 8'h7F, 8'h40, 1'b0);
    chk("to7F.end", 32'(w_end_w), 32'd0);

    // Load 0 without enable, then step down across the lower end.
    load = 1'b1; load_val = 8'h00; en = 1'b0;
    step(); chk_w("ld00", 8'h00, 8'h00, 1'b0);
    load = 1'b0;
    #1;
    chk("ld00.end", 32'(w_end_w), 32'd1);
    chk("ld00.sig", 32'(w_sig_s), 32'd1);
    en = 1'b1;
    step(); chk_w("wrapdn", 8'hFF, 8'h80, 1'b1); chk_s("satdn", 8'h00, 8'h00, 1'b0);

    // Reversing at the end crosses it again: back-to-back wrap pulses.
    up = 1'b1;
    step(); chk_w("rewrap", 8'h00, 8'h00, 1'b1); chk_s("satup", 8'h01, 8'h01, 1'b0);

    // Disabled: hold, pulse clears.
    en = 1'b0;
    step(); chk_w("hold", 8'h00, 8'h00, 1'b0); chk_s("hold", 8'h01, 8'h01, 1'b0);

    // Asynchronous reset between edges while at 0x5A.
    load = 1'b1; load_val = 8'h5A;
    step(); chk_w("ld5A", 8'h5A, 8'h77, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_w("arst", 8'h00, 8'h00, 1'b0); chk_s("arst", 8'h00, 8'h00, 1'b0);
    chk("arst.sig", 32'(w_sig_w), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arel.sig", 32'(w_sig_w), 32'd1);
    step(); chk_w("resume", 8'h01, 8'h01, 1'b0); chk_s("resume", 8'h01, 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
